// File: rtl/imem_uart_loader_pkg.sv
// Shared constants and RX state encoding for the UART instruction-memory loader.
// IMEM_DEPTH is shared with IMem and PcUnit.
package imem_uart_loader_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int IMEM_DEPTH       = 256;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/imem_uart_loader_uart_rx_8n1.sv
// 8N1 UART receiver: input synchronizer, bit timer and framing FSM.
// state | meaning: IDLE wait start edge | START confirm start mid-bit | DATA shift 8 bits | STOP check stop bit
module uart_rx_8n1
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err_pulse,
  output logic       o_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic          r_rx_s1, r_rx_s2;
  rx_state_t     r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_valid, w_ferr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_state   <= RX_IDLE;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_rx_s1   <= i_rx;
      r_rx_s2   <= r_rx_s1;
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + 1'b1;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_valid     = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_timer_nxt = '0;
        if (!r_rx_s2) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_timer == HALF) begin
          w_timer_nxt = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_timer == LAST) begin
          w_timer_nxt = '0;
          w_shift_nxt = {r_rx_s2, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_timer == LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = RX_IDLE;
          w_valid     = r_rx_s2;
          w_ferr      = !r_rx_s2;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // Valid is combinational so the top can register the write strobe on the stop-sample edge.
  assign o_byte            = r_shift;
  assign o_byte_valid      = w_valid;
  assign o_frame_err_pulse = w_ferr;
  assign o_busy            = (r_state != RX_IDLE);

endmodule

// File: rtl/imem_uart_loader.sv
// Program loader: assembles UART bytes big-endian into words, writes IMem,
// and holds the CPU in reset for the duration of the load window.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_uart_rx,
  input  logic              i_load_en,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_wdata,
  output logic              o_cpu_hold,
  output logic [ADDR_W:0]   o_word_cnt,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [7:0]        w_byte;
  logic              w_byte_valid, w_ferr_pulse, w_busy;
  logic              r_le_s1, r_le_s2, r_le_d;
  logic              r_cpu_hold, r_im_we, r_ferr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [31:0]       r_wdata;
  logic [1:0]        r_idx;
  logic              w_le_rise, w_le_fall, w_accept;
  logic [1:0]        w_lane;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_rx             (i_uart_rx),
    .o_byte           (w_byte),
    .o_byte_valid     (w_byte_valid),
    .o_frame_err_pulse(w_ferr_pulse),
    .o_busy           (w_busy)
  );

  assign w_le_rise = r_le_s2 & ~r_le_d;
  assign w_le_fall = ~r_le_s2 & r_le_d;
  // A byte landing on the load-start edge is dropped so the clear wins.
  assign w_accept  = w_byte_valid & r_le_s2 & ~w_le_rise;
  assign w_lane    = 2'd3 - r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_le_s1    <= 1'b0;
      r_le_s2    <= 1'b0;
      r_le_d     <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_im_we    <= 1'b0;
      r_ferr     <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_idx      <= '0;
    end else begin
      r_le_s1    <= i_load_en;
      r_le_s2    <= r_le_s1;
      r_le_d     <= r_le_s2;
      r_cpu_hold <= r_le_s2;
      r_im_we    <= w_accept && (r_idx == 2'd3);
      if (w_accept) r_wdata[{w_lane, 3'b000} +: 8] <= w_byte;
      if (w_le_rise) begin
        r_addr <= '0;
        r_cnt  <= '0;
        r_idx  <= '0;
        r_ferr <= 1'b0;
      end else begin
        // Counters advance after the strobe cycle even if the window just closed.
        if (r_im_we) begin
          r_addr <= r_addr + 1'b1;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end
        if (w_le_fall) r_idx <= '0;
        else if (w_accept) r_idx <= r_idx + 1'b1;
        if (w_ferr_pulse && r_le_s2) r_ferr <= 1'b1;
      end
    end
  end

  assign o_im_we     = r_im_we;
  assign o_im_addr   = r_addr;
  assign o_im_wdata  = r_wdata;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_word_cnt  = r_cnt;
  assign o_frame_err = r_ferr;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed + randomized bench for imem_uart_loader against a queue-based load model.
module tb_imem_uart_loader;
  import imem_uart_loader_pkg::*;

  localparam int CPB   = 16;
  localparam int CPB_F = 4;
  localparam int AW    = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rx = 1'b1, load_en = 1'b0, rx_f = 1'b1, load_en_f = 1'b0;

  logic          we, hold, ferr, busy;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [AW:0]   cnt;
  logic          we_f, hold_f, ferr_f, busy_f;
  logic [AW-1:0] addr_f;
  logic [31:0]   wdata_f;
  logic [AW:0]   cnt_f;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx), .i_load_en(load_en),
    .o_im_we(we), .o_im_addr(addr), .o_im_wdata(wdata), .o_cpu_hold(hold),
    .o_word_cnt(cnt), .o_frame_err(ferr), .o_busy(busy)
  );

  // Second instance with a fast bit rate keeps the 257-word wrap stream short.
  imem_uart_loader #(.CLKS_PER_BIT(CPB_F), .ADDR_W(AW)) dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_f), .i_load_en(load_en_f),
    .o_im_we(we_f), .o_im_addr(addr_f), .o_im_wdata(wdata_f), .o_cpu_hold(hold_f),
    .o_word_cnt(cnt_f), .o_frame_err(ferr_f), .o_busy(busy_f)
  );

  int checks = 0, failures = 0;
  logic [39:0] wq[$], wq_f[$], eq[$], eq_f[$];
  int run_len = 0, max_run = 0;

  always @(negedge clk) begin
    if (we) begin
      wq.push_back({addr, wdata});
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else run_len = 0;
    if (we_f) wq_f.push_back({addr_f, wdata_f});
  end

  bit          m_load = 0, m_ferr = 0;
  int          m_addr = 0, m_cnt = 0, m_idx = 0;
  logic [31:0] m_word = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_rise();
    m_load = 1; m_addr = 0; m_cnt = 0; m_idx = 0; m_ferr = 0;
  endtask

  task automatic model_fall();
    m_load = 0; m_idx = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!m_load) return;
    if (!ok) begin
      m_ferr = 1;
      return;
    end
    m_word = {m_word[23:0], b};
    m_idx++;
    if (m_idx == 4) begin
      eq.push_back({8'(m_addr), m_word});
      m_addr = (m_addr + 1) % IMEM_DEPTH;
      if (m_cnt < IMEM_DEPTH) m_cnt++;
      m_idx = 0;
    end
  endtask

  task automatic drive(input logic v, input bit fast);
    if (fast) rx_f = v;
    else rx = v;
  endtask

  // Called on a falling clock edge; leaves one idle bit (two after a bad stop bit).
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit fast);
    int cpb;
    logic [9:0] fr;
    cpb = fast ? CPB_F : CPB;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(fr[i], fast);
      repeat (cpb) @(negedge clk);
    end
    drive(1'b1, fast);
    repeat (stop_ok ? cpb : 2 * cpb) @(negedge clk);
    if (!fast) model_byte(b, stop_ok);
  endtask

  task automatic send_word(input logic [31:0] w, input bit fast);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1, fast);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(wq.size()), 64'(eq.size()));
    while (wq.size() > 0 && eq.size() > 0) chk(tag, wq.pop_front(), eq.pop_front());
    wq.delete();
    eq.delete();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_hold", hold, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nowrite", 64'(wq.size()), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_hold", hold, 0);

    load_en = 1'b1;
    repeat (4) @(negedge clk);
    model_rise();
    chk("load_hold", hold, 1);
    send_word(32'h2008_0005, 0);
    repeat (4) @(negedge clk);
    check_writes("word1");
    chk("word1_cnt", cnt, 64'(m_cnt));
    chk("word1_addr", addr, 64'(m_addr));

    send_word(32'h8C01_0000, 0);
    chk("busy_gap", busy, 0);
    send_word(32'hAC02_0004, 0);
    chk("busy_gap2", busy, 0);
    w = $urandom;
    send_word(w, 0);
    repeat (4) @(negedge clk);
    check_writes("multi");
    chk("multi_cnt", cnt, 64'(m_cnt));

    load_en = 1'b0;
    repeat (4) @(negedge clk);
    model_fall();
    load_en = 1'b1;
    repeat (4) @(negedge clk);
    model_rise();
    send_byte(8'h11, 1'b0, 0);
    send_word(32'hAABB_CCDD, 0);
    repeat (4) @(negedge clk);
    chk("ferr_sticky", ferr, 64'(m_ferr));
    check_writes("ferr_word");
    chk("ferr_addr", addr, 64'(m_addr));

    send_byte(8'($urandom), 1'b1, 0);
    send_byte(8'($urandom), 1'b1, 0);
    load_en = 1'b0;
    model_fall();
    repeat (2) @(negedge clk);
    chk("fall_hold_still", hold, 1);
    @(negedge clk);
    chk("fall_hold_drop", hold, 0);
    repeat (4) @(negedge clk);
    send_word($urandom, 0);
    repeat (4) @(negedge clk);
    check_writes("off_ignored");
    chk("off_cnt", cnt, 64'(m_cnt));
    chk("off_ferr", ferr, 64'(m_ferr));
    load_en = 1'b1;
    repeat (4) @(negedge clk);
    model_rise();
    chk("reload_cnt", cnt, 0);
    chk("reload_addr", addr, 0);
    chk("reload_ferr", ferr, 0);
    send_word($urandom, 0);
    repeat (4) @(negedge clk);
    check_writes("reload_word");

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_hi", busy, 1);
    repeat (30) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    send_word($urandom, 0);
    repeat (4) @(negedge clk);
    check_writes("post_glitch");
    chk("post_glitch_cnt", cnt, 64'(m_cnt));

    load_en_f = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < IMEM_DEPTH + 1; i++) begin
      w = $urandom;
      eq_f.push_back({8'(i % IMEM_DEPTH), w});
      send_word(w, 1);
    end
    repeat (4) @(negedge clk);
    chk("wrap_count", 64'(wq_f.size()), 64'(IMEM_DEPTH + 1));
    if (wq_f.size() == IMEM_DEPTH + 1) chk("wrap_last_addr", 64'(wq_f[IMEM_DEPTH][39:32]), 0);
    while (wq_f.size() > 0 && eq_f.size() > 0) chk("wrap_write", wq_f.pop_front(), eq_f.pop_front());
    chk("wrap_cnt_sat", cnt_f, 64'(IMEM_DEPTH));
    chk("wrap_addr_next", addr_f, 1);
    chk("wrap_ferr", ferr_f, 0);
    chk("we_width", 64'(max_run), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
